ex_mdu: RTL and testbench

- Iterative RV32M multiply/divide unit, instantiated beside the combinational execute stage.
- Accepts one MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU operation, computes it one bit per cycle, and returns rd write-back signals.
- Raises hold_flag_o so ctrl stalls the pipeline while an operation is in flight; a jump flush aborts it.
- Generalises the single-cycle ALU path to width-parametrised, multi-cycle arithmetic with a start/valid handshake.

---
 rtl/ex_mdu_pkg.sv | 24 ++
 rtl/ex_mdu_sign_fix.sv | 34 +++
 rtl/ex_mdu.sv | 89 ++++++++
 tb/tb_ex_mdu.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/ex_mdu_pkg.sv
// ex_mdu_pkg: shared M-extension encodings, MDU states and operand signedness helpers.
package ex_mdu_pkg;
  localparam logic [6:0] INST_TYPE_R_M = 7'b0110011;
  localparam logic [6:0] FUNC7_M       = 7'b0000001;
  localparam logic [2:0] INST_MUL    = 3'b000;
  localparam logic [2:0] INST_MULH   = 3'b001;
  localparam logic [2:0] INST_MULHSU = 3'b010;
  localparam logic [2:0] INST_MULHU  = 3'b011;
  localparam logic [2:0] INST_DIV    = 3'b100;
  localparam logic [2:0] INST_DIVU   = 3'b101;
  localparam logic [2:0] INST_REM    = 3'b110;
  localparam logic [2:0] INST_REMU   = 3'b111;
  typedef enum logic [1:0] {MDU_IDLE = 2'd0, MDU_CALC = 2'd1, MDU_DONE = 2'd2} mdu_state_e;
  function automatic logic is_m_op(input logic [6:0] opcode, input logic [6:0] func7);
    return opcode == INST_TYPE_R_M && func7 == FUNC7_M;
  endfunction
  function automatic logic op1_signed(input logic [2:0] f3);
    return f3 inside {INST_MULH, INST_MULHSU, INST_DIV, INST_REM};
  endfunction
  // MUL only keeps the low half, so treating it as unsigned is harmless.
  function automatic logic op2_signed(input logic [2:0] f3);
    return !(f3 inside {INST_MUL, INST_MULHSU, INST_MULHU, INST_DIVU, INST_REMU});
  endfunction
endpackage

// File: rtl/ex_mdu_sign_fix.sv
// ex_mdu_sign_fix: operand magnitude extraction at entry and sign correction/result selection at DONE.
// Ports: i_func3/i_op1/i_op2 -> o_neg1/o_neg2/o_mag1/o_mag2 (entry side);
//        i_rfunc3/i_rneg1/i_rneg2/i_fast/i_acc -> o_result (completion side).
module ex_mdu_sign_fix import ex_mdu_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic [2:0]        i_func3,
  input  logic [XLEN-1:0]   i_op1,
  input  logic [XLEN-1:0]   i_op2,
  output logic              o_neg1,
  output logic              o_neg2,
  output logic [XLEN-1:0]   o_mag1,
  output logic [XLEN-1:0]   o_mag2,
  input  logic [2:0]        i_rfunc3,
  input  logic              i_rneg1,
  input  logic              i_rneg2,
  input  logic              i_fast,
  input  logic [2*XLEN-1:0] i_acc,
  output logic [XLEN-1:0]   o_result
);
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quo;
  logic [XLEN-1:0]   w_rem;
  assign o_neg1 = op1_signed(i_func3) & i_op1[XLEN-1];
  assign o_neg2 = op2_signed(i_func3) & i_op2[XLEN-1];
  assign o_mag1 = o_neg1 ? -i_op1 : i_op1;
  assign o_mag2 = o_neg2 ? -i_op2 : i_op2;
  // Fast-path results are preloaded into the accumulator already in final form.
  assign w_prod = (i_rneg1 ^ i_rneg2) ? -i_acc : i_acc;
  assign w_quo  = (!i_fast && (i_rneg1 ^ i_rneg2)) ? -i_acc[XLEN-1:0] : i_acc[XLEN-1:0];
  assign w_rem  = (!i_fast && i_rneg1) ? -i_acc[2*XLEN-1:XLEN] : i_acc[2*XLEN-1:XLEN];
  assign o_result = i_rfunc3[2] ? (i_rfunc3[1] ? w_rem : w_quo)
                  : (i_rfunc3 == INST_MUL ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN]);
endmodule

// File: rtl/ex_mdu.sv
// ex_mdu: iterative multiply/divide unit, one bit per cycle, with start/valid handshake and pipeline hold.
// Ports: clk, rst_n; start_i/func3_i/op1_i/op2_i/rd_addr_i request; kill_i flush;
//        rd_data_o/rd_addr_o/reg_wen_o write-back; hold_flag_o stall request.
module ex_mdu import ex_mdu_pkg::*; #(
  parameter  int XLEN  = 32,
  localparam int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [2:0]      func3_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            kill_i,
  output logic [XLEN-1:0] rd_data_o,
  output logic [4:0]      rd_addr_o,
  output logic            reg_wen_o,
  output logic            hold_flag_o
);
  mdu_state_e          r_state, w_next;
  logic [CNT_W-1:0]    r_cnt;
  logic [2:0]          r_f3;
  logic [4:0]          r_rd;
  logic                r_n1, r_n2, r_fast;
  logic [XLEN-1:0]     r_b;
  logic [2*XLEN-1:0]   r_acc;
  logic                w_accept, w_dz, w_ovf, w_n1, w_n2, w_ge;
  logic [XLEN-1:0]     w_mag1, w_mag2, w_result, w_sub;
  logic [XLEN:0]       w_madd, w_top;
  logic [2*XLEN-1:0]   w_step;
  ex_mdu_sign_fix #(.XLEN(XLEN)) u_fix (
    .i_func3(func3_i), .i_op1(op1_i), .i_op2(op2_i),
    .o_neg1(w_n1), .o_neg2(w_n2), .o_mag1(w_mag1), .o_mag2(w_mag2),
    .i_rfunc3(r_f3), .i_rneg1(r_n1), .i_rneg2(r_n2), .i_fast(r_fast),
    .i_acc(r_acc), .o_result(w_result)
  );
  assign w_accept = start_i && !kill_i;
  assign w_dz     = func3_i[2] && op2_i == '0;
  assign w_ovf    = func3_i inside {INST_DIV, INST_REM} && op1_i == {1'b1, {(XLEN-1){1'b0}}} && &op2_i;
  // Multiply: acc = {partial, multiplier}; add multiplicand on lsb, shift right.
  assign w_madd   = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, r_acc[0] ? r_b : {XLEN{1'b0}}};
  // Divide: acc = {remainder, quotient}; shift left, subtract divisor if it fits.
  assign w_top    = r_acc[2*XLEN-1:XLEN-1];
  assign w_ge     = w_top >= {1'b0, r_b};
  assign w_sub    = w_top[XLEN-1:0] - r_b;
  assign w_step   = r_f3[2] ? {w_ge ? w_sub : w_top[XLEN-1:0], r_acc[XLEN-2:0], w_ge}
                            : {w_madd, r_acc[XLEN-1:1]};
  always_comb begin
    w_next = r_state;
    case (r_state)
      MDU_IDLE: if (w_accept) w_next = (w_dz || w_ovf) ? MDU_DONE : MDU_CALC;
      MDU_CALC: if (kill_i) w_next = MDU_IDLE; else if (r_cnt == CNT_W'(1)) w_next = MDU_DONE;
      default:  w_next = MDU_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= MDU_IDLE;
    else r_state <= w_next;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_cnt  <= '0;
      r_f3   <= '0;
      r_rd   <= '0;
      r_n1   <= 1'b0;
      r_n2   <= 1'b0;
      r_fast <= 1'b0;
      r_b    <= '0;
      r_acc  <= '0;
    end else if (r_state == MDU_IDLE && w_accept) begin
      r_cnt  <= CNT_W'(XLEN);
      r_f3   <= func3_i;
      r_rd   <= rd_addr_i;
      r_n1   <= w_n1;
      r_n2   <= w_n2;
      r_fast <= w_dz || w_ovf;
      r_b    <= func3_i[2] ? w_mag2 : w_mag1;
      r_acc  <= w_dz  ? {op1_i, {XLEN{1'b1}}}
              : w_ovf ? {{XLEN{1'b0}}, 1'b1, {(XLEN-1){1'b0}}}
              : {{XLEN{1'b0}}, func3_i[2] ? w_mag1 : w_mag2};
    end else if (r_state == MDU_CALC) begin
      r_acc <= w_step;
      r_cnt <= r_cnt - 1'b1;
    end
  assign rd_data_o   = r_state == MDU_DONE ? w_result : '0;
  assign rd_addr_o   = r_rd;
  assign reg_wen_o   = r_state == MDU_DONE && !kill_i;
  assign hold_flag_o = (r_state == MDU_IDLE && w_accept) || (r_state == MDU_CALC && !kill_i);
endmodule

// File: tb/tb_ex_mdu.sv
// tb_ex_mdu: directed scoreboard bench for ex_mdu (XLEN=32 and XLEN=16 instances).
module tb_ex_mdu;
  import ex_mdu_pkg::*;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        kill = 1'b0;
  logic [2:0]  func3 = '0;
  logic [31:0] op1 = '0;
  logic [31:0] op2 = '0;
  logic [4:0]  rd_addr = '0;
  logic        sel16 = 1'b0;
  logic [31:0] d32;
  logic [15:0] d16;
  logic [4:0]  a32, a16;
  logic        wen32, wen16, hold32, hold16;
  logic [31:0] m_data;
  logic [4:0]  m_addr;
  logic        m_wen, m_hold;
  logic [36:0] sb[$];
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  ex_mdu #(.XLEN(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .start_i(start), .func3_i(func3), .op1_i(op1), .op2_i(op2),
    .rd_addr_i(rd_addr), .kill_i(kill), .rd_data_o(d32), .rd_addr_o(a32),
    .reg_wen_o(wen32), .hold_flag_o(hold32)
  );
  ex_mdu #(.XLEN(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start_i(start), .func3_i(func3), .op1_i(op1[15:0]), .op2_i(op2[15:0]),
    .rd_addr_i(rd_addr), .kill_i(kill), .rd_data_o(d16), .rd_addr_o(a16),
    .reg_wen_o(wen16), .hold_flag_o(hold16)
  );
  assign m_data = sel16 ? {16'h0, d16} : d32;
  assign m_addr = sel16 ? a16 : a32;
  assign m_wen  = sel16 ? wen16 : wen32;
  assign m_hold = sel16 ? hold16 : hold32;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask
  task automatic do_op(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp, input int lat);
    int n, h;
    func3 = f3; op1 = a; op2 = b; rd_addr = rd; start = 1'b1;
    #1;
    sb.push_back({rd, exp});
    n = 0; h = 0;
    while (!m_wen && n < 100) begin
      h += int'(m_hold);
      @(posedge clk); #1;
      start = 1'b0;
      n++;
    end
    chk({tag, "_latency"}, n, lat);
    chk({tag, "_hold_cycles"}, h, lat);
    chk({tag, "_hold_in_done"}, {31'h0, m_hold}, 0);
    @(posedge clk); #1;
  endtask
  always @(negedge clk) begin
    if (rst_n && m_wen) begin
      if (sb.size() == 0) chk("spurious_wen", {31'h0, m_wen}, 0);
      else begin
        logic [36:0] e;
        e = sb.pop_front();
        chk("rd_data", m_data, e[31:0]);
        chk("rd_addr", {27'h0, m_addr}, {27'h0, e[36:32]});
      end
    end
  end
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data", d32, 0);
    chk("rst_addr", {27'h0, a32}, 0);
    chk("rst_wen", {31'h0, wen32}, 0);
    chk("rst_hold", {31'h0, hold32}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_op("mul",    INST_MUL,    32'd7,        32'hFFFFFFFD, 5'd3,  32'hFFFFFFEB, 33);
    do_op("mulh",   INST_MULH,   32'h80000000, 32'h80000000, 5'd4,  32'h40000000, 33);
    do_op("mulhu",  INST_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5,  32'hFFFFFFFE, 33);
    do_op("mulhsu", INST_MULHSU, 32'hFFFFFFFF, 32'd2,        5'd6,  32'hFFFFFFFF, 33);
    do_op("div",    INST_DIV,    32'hFFFFFFF9, 32'd2,        5'd7,  32'hFFFFFFFD, 33);
    do_op("rem",    INST_REM,    32'hFFFFFFF9, 32'd2,        5'd8,  32'hFFFFFFFF, 33);
    do_op("divu",   INST_DIVU,   32'd100,      32'd7,        5'd0,  32'd14,       33);
    do_op("remu",   INST_REMU,   32'd100,      32'd7,        5'd31, 32'd2,        33);
    do_op("div0",   INST_DIV,    32'd5,        32'd0,        5'd9,  32'hFFFFFFFF, 1);
    do_op("remu0",  INST_REMU,   32'd5,        32'd0,        5'd10, 32'd5,        1);
    do_op("divovf", INST_DIV,    32'h80000000, 32'hFFFFFFFF, 5'd11, 32'h80000000, 1);
    do_op("removf", INST_REM,    32'h80000000, 32'hFFFFFFFF, 5'd12, 32'd0,        1);
    func3 = INST_MUL; op1 = 32'd9; op2 = 32'd9; rd_addr = 5'd13; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    kill = 1'b1;
    #1;
    chk("kill_calc_hold", {31'h0, hold32}, 0);
    chk("kill_calc_wen", {31'h0, wen32}, 0);
    @(posedge clk); #1;
    kill = 1'b0;
    #1;
    chk("kill_idle_hold", {31'h0, hold32}, 0);
    chk("kill_idle_wen", {31'h0, wen32}, 0);
    @(posedge clk); #1;
    do_op("after_kill", INST_DIVU, 32'd100, 32'd7, 5'd14, 32'd14, 33);
    func3 = INST_DIVU; op1 = 32'd5; op2 = 32'd0; rd_addr = 5'd15; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; kill = 1'b1;
    #1;
    chk("kill_done_wen", {31'h0, wen32}, 0);
    @(posedge clk); #1;
    kill = 1'b0;
    @(posedge clk); #1;
    func3 = INST_MUL; op1 = 32'd3; op2 = 32'd3; rd_addr = 5'd17; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("mid_calc_hold", {31'h0, hold32}, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_data", d32, 0);
    chk("arst_addr", {27'h0, a32}, 0);
    chk("arst_wen", {31'h0, wen32}, 0);
    chk("arst_hold", {31'h0, hold32}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    sel16 = 1'b1;
    @(posedge clk); #1;
    do_op("divu16", INST_DIVU, 32'h0000FFFF, 32'h00000003, 5'd18, 32'h00005555, 17);
    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
